// File: rtl/sr_frame_sequencer_if.sv
// Purpose: control/status bundle between the SR frame sequencer and its ROM, LUT, frame memory and datapath.
// Latency: none; this file only declares wires.
// Backpressure: none; start/lut_reload are single-cycle requests and every other signal is a free-running strobe or tag.
interface sr_frame_sequencer_if #(
  parameter int WIDTH  = 114,
  parameter int HEIGHT = 172,
  parameter int ADDR_W = 15,
  parameter int LUT_AW = 12
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic              start;
  logic              lut_reload;
  logic [LUT_AW-1:0] rom_addr1;
  logic [LUT_AW-1:0] rom_addr2;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr1;
  logic [LUT_AW-1:0] lut_waddr2;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic              lb_en;
  logic              out_valid;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic              lut_ready;
  logic              busy;
  logic              frame_done;

  // Sequencer side.
  modport master (
    input  start, lut_reload,
    output rom_addr1, rom_addr2, lut_we, lut_waddr1, lut_waddr2,
    output pix_rd, pix_addr, lb_en, out_valid, out_x, out_y,
    output lut_ready, busy, frame_done
  );

  // Environment side.
  modport slave (
    output start, lut_reload,
    input  rom_addr1, rom_addr2, lut_we, lut_waddr1, lut_waddr2,
    input  pix_rd, pix_addr, lb_en, out_valid, out_x, out_y,
    input  lut_ready, busy, frame_done
  );
endinterface

// File: rtl/sr_frame_sequencer.sv
// Purpose: preloads the SR LUT from ROM two words per cycle, then streams one frame and tags datapath outputs.
// Latency: pixel (0,0) reaches the output slot PIPE_LAT cycles after the first pix_rd; frame_done follows the last slot.
// Backpressure: none; a frame runs free once started, and start/lut_reload are ignored while streaming or draining.
module sr_frame_sequencer #(
  parameter int WIDTH     = 114,
  parameter int HEIGHT    = 172,
  parameter int ADDR_W    = 15,
  parameter int LUT_DEPTH = 3392,
  parameter int LUT_AW    = 12,
  parameter int PIPE_LAT  = 232,
  parameter int BORDER    = 2
) (
  input logic                  clk,
  input logic                  rst,
  sr_frame_sequencer_if.master bus
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = LUT_AW - 1;
  localparam int LW = $clog2(PIPE_LAT + 1);

  localparam logic [BW-1:0] BASE_LAST = BW'(LUT_DEPTH / 2 - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(PIPE_LAT - 1);
  localparam logic [LW-1:0] LAT_END   = LW'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LFLUSH, S_READY, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t            state, nxt;
  logic [BW-1:0]     base;
  logic              pending;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr1, lut_waddr2;
  logic              lut_ready;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic [ADDR_W-1:0] pix_addr;
  logic              rd_d1;
  logic              lb_en;
  logic [LW-1:0]     lat_cnt;
  logic              slot_on;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;

  logic [LUT_AW-1:0] rom_addr1, rom_addr2;
  logic              pix_rd, busy, frame_done, out_valid;
  logic              in_last, slot_last, lat_arm;

  assign in_last   = (in_x == X_LAST) && (in_y == Y_LAST);
  assign slot_last = slot_on && (out_x == X_LAST) && (out_y == Y_LAST);
  // The latency counter only runs until the first output slot opens.
  assign lat_arm   = ((state == S_STREAM) || (state == S_DRAIN)) && (lat_cnt != LAT_END);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state decode and the outputs that follow directly from the state.
  always_comb begin
    nxt        = state;
    rom_addr1  = '0;
    rom_addr2  = '0;
    pix_rd     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start || bus.lut_reload) nxt = S_LOAD;
      end
      S_LOAD: begin
        rom_addr1 = {base, 1'b0};
        rom_addr2 = {base, 1'b1};
        if (base == BASE_LAST) nxt = S_LFLUSH;
      end
      S_LFLUSH: begin
        // The final ROM word pair is written this cycle.
        nxt = (pending || bus.start) ? S_STREAM : S_READY;
      end
      S_READY: begin
        busy = 1'b0;
        if (bus.lut_reload) nxt = S_LOAD;
        else if (bus.start) nxt = S_STREAM;
      end
      S_STREAM: begin
        pix_rd = 1'b1;
        if (in_last) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (slot_last) nxt = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        nxt        = S_READY;
      end
      default: begin
        busy = 1'b0;
        nxt  = S_IDLE;
      end
    endcase
  end

  // LUT preload: walk base over the ROM, and delay addresses by the one-cycle ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      lut_we     <= 1'b0;
      lut_waddr1 <= '0;
      lut_waddr2 <= '0;
    end else begin
      if (state == S_LOAD) base <= (base == BASE_LAST) ? '0 : base + 1'b1;
      lut_we     <= (state == S_LOAD);
      lut_waddr1 <= rom_addr1;
      lut_waddr2 <= rom_addr2;
    end
  end

  // LUT-valid flag and a start request remembered across a preload.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_ready <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (state == S_LFLUSH)   lut_ready <= 1'b1;
      else if (nxt == S_LOAD)  lut_ready <= 1'b0;

      if (state == S_LFLUSH) begin
        pending <= 1'b0;
      end else if (bus.start && ((state == S_IDLE) || (state == S_LOAD) ||
                                 ((state == S_READY) && bus.lut_reload))) begin
        pending <= 1'b1;
      end
    end
  end

  // Input raster; pix_addr is a running count that always equals in_y*WIDTH+in_x.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_x     <= '0;
      in_y     <= '0;
      pix_addr <= '0;
      rd_d1    <= 1'b0;
    end else begin
      rd_d1 <= pix_rd;
      if (pix_rd) begin
        if (in_last) begin
          in_x     <= '0;
          in_y     <= '0;
          pix_addr <= '0;
        end else begin
          pix_addr <= pix_addr + 1'b1;
          if (in_x == X_LAST) begin
            in_x <= '0;
            in_y <= in_y + 1'b1;
          end else begin
            in_x <= in_x + 1'b1;
          end
        end
      end
    end
  end

  // Line buffer runs from two cycles after the first read until the frame completes.
  always_ff @(posedge clk) begin
    if (rst)                lb_en <= 1'b0;
    else if (nxt == S_DONE) lb_en <= 1'b0;
    else if (rd_d1)         lb_en <= 1'b1;
  end

  // Pipeline latency count, then the raster walk of output slots; the final slot goes straight to DONE, which clears the tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
      slot_on <= 1'b0;
      out_x   <= '0;
      out_y   <= '0;
    end else begin
      if (state == S_DONE) lat_cnt <= '0;
      else if (lat_arm)    lat_cnt <= lat_cnt + 1'b1;

      if (lat_arm && (lat_cnt == LAT_LAST)) begin
        slot_on <= 1'b1;
      end else if (slot_on) begin
        if (slot_last) begin
          slot_on <= 1'b0;
          out_x   <= '0;
          out_y   <= '0;
        end else if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end
    end
  end

  assign out_valid = slot_on &&
                     (int'(out_x) >= BORDER) && (int'(out_x) < WIDTH - BORDER) &&
                     (int'(out_y) >= BORDER) && (int'(out_y) < HEIGHT - BORDER);

  assign bus.rom_addr1  = rom_addr1;
  assign bus.rom_addr2  = rom_addr2;
  assign bus.lut_we     = lut_we;
  assign bus.lut_waddr1 = lut_waddr1;
  assign bus.lut_waddr2 = lut_waddr2;
  assign bus.pix_rd     = pix_rd;
  assign bus.pix_addr   = pix_addr;
  assign bus.lb_en      = lb_en;
  assign bus.out_valid  = out_valid;
  assign bus.out_x      = out_x;
  assign bus.out_y      = out_y;
  assign bus.lut_ready  = lut_ready;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_sr_frame_sequencer.sv
// Purpose: self-checking bench for sr_frame_sequencer against a phase/offset reference model.
// Latency: every output is compared every cycle, on the falling edge.
// Backpressure: none; the reference model advances one step per clock.
module tb_sr_frame_sequencer;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 15;
  localparam int LD = 16;
  localparam int LA = 12;
  localparam int P  = 20;
  localparam int B  = 2;
  localparam int N  = W * H;
  localparam int D2 = LD / 2;
  localparam int VALID_PER_FRAME = (W - 2 * B) * (H - 2 * B);

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;
  localparam int M_FRAME = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_frame_sequencer_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .LUT_AW(LA)) bus ();

  sr_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .LUT_DEPTH(LD),
    .LUT_AW(LA), .PIPE_LAT(P), .BORDER(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a coarse phase plus the cycle offset k within it.
  // LOAD covers the ROM walk (k < D2) and the flush cycle (k == D2).
  // FRAME covers reads (k < N), output slots (P <= k < P+N) and the done cycle (k == P+N).
  int m_mode;
  int m_k;
  bit m_pend;

  int c_we, c_rd, c_vld, c_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    int e_rd, e_lb, e_vld, e_x, e_y, e_done, e_busy, e_rdy, e_we, s;
    e_rd = 0; e_lb = 0; e_vld = 0; e_x = 0; e_y = 0;
    e_done = 0; e_busy = 0; e_rdy = 0; e_we = 0;
    case (m_mode)
      M_IDLE: begin
        check_val("idle_rom_addr1", 32'(bus.rom_addr1), 0);
        check_val("idle_rom_addr2", 32'(bus.rom_addr2), 0);
        check_val("idle_lut_waddr1", 32'(bus.lut_waddr1), 0);
        check_val("idle_lut_waddr2", 32'(bus.lut_waddr2), 0);
        check_val("idle_pix_addr", 32'(bus.pix_addr), 0);
      end
      M_LOAD: begin
        e_busy = 1;
        e_we   = (m_k >= 1) ? 1 : 0;
        if (m_k < D2) begin
          check_val("rom_addr1", 32'(bus.rom_addr1), 2 * m_k);
          check_val("rom_addr2", 32'(bus.rom_addr2), 2 * m_k + 1);
        end
        if (m_k >= 1) begin
          check_val("lut_waddr1", 32'(bus.lut_waddr1), 2 * (m_k - 1));
          check_val("lut_waddr2", 32'(bus.lut_waddr2), 2 * (m_k - 1) + 1);
        end
      end
      M_READY: e_rdy = 1;
      default: begin
        e_busy = 1;
        e_rdy  = 1;
        e_rd   = (m_k < N) ? 1 : 0;
        e_lb   = (m_k >= 2 && m_k < P + N) ? 1 : 0;
        e_done = (m_k == P + N) ? 1 : 0;
        s = m_k - P;
        if (s >= 0 && s < N) begin
          e_x   = s % W;
          e_y   = s / W;
          e_vld = (e_x >= B && e_x < W - B && e_y >= B && e_y < H - B) ? 1 : 0;
        end
        if (e_rd == 1) check_val("pix_addr", 32'(bus.pix_addr), m_k);
      end
    endcase
    check_val("pix_rd", 32'(bus.pix_rd), e_rd);
    check_val("lb_en", 32'(bus.lb_en), e_lb);
    check_val("out_valid", 32'(bus.out_valid), e_vld);
    check_val("out_x", 32'(bus.out_x), e_x);
    check_val("out_y", 32'(bus.out_y), e_y);
    check_val("frame_done", 32'(bus.frame_done), e_done);
    check_val("busy", 32'(bus.busy), e_busy);
    check_val("lut_ready", 32'(bus.lut_ready), e_rdy);
    check_val("lut_we", 32'(bus.lut_we), e_we);
    if (bus.lut_we === 1'b1)     c_we++;
    if (bus.pix_rd === 1'b1)     c_rd++;
    if (bus.out_valid === 1'b1)  c_vld++;
    if (bus.frame_done === 1'b1) c_done++;
  endtask

  task automatic model_advance(input bit s, input bit r, input bit rs);
    if (rs) begin
      m_mode = M_IDLE; m_k = 0; m_pend = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (s || r) begin m_mode = M_LOAD; m_k = 0; m_pend = s; end
      M_LOAD: begin
        if (m_k < D2) begin
          if (s) m_pend = 1;
          m_k++;
        end else begin
          m_mode = m_pend ? M_FRAME : M_READY;
          m_k = 0; m_pend = 0;
        end
      end
      M_READY: begin
        if (r)      begin m_mode = M_LOAD;  m_k = 0; m_pend = s; end
        else if (s) begin m_mode = M_FRAME; m_k = 0; end
      end
      default: begin
        if (m_k == P + N) begin m_mode = M_READY; m_k = 0; end
        else m_k++;
      end
    endcase
  endtask

  task automatic tick(input bit s, input bit r, input bit rs);
    bus.start = s; bus.lut_reload = r; rst = rs;
    @(negedge clk);
    check_outputs();
    model_advance(s, r, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    c_we = 0; c_rd = 0; c_vld = 0; c_done = 0;
  endtask

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (m_mode != M_READY && i < 400) begin
      tick(0, 0, 0);
      i++;
    end
    check_val({tag, "_idle_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, r, rs;
    int i;
    rst = 1'b1; bus.start = 1'b0; bus.lut_reload = 1'b0;
    m_mode = M_IDLE; m_k = 0; m_pend = 0;
    clear_counts();
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick(0, 0, 1);

    // First start from IDLE: preload then stream without a second start.
    clear_counts();
    tick(1, 0, 0);
    wait_ready("s1");
    check_val("s1_lut_we_cycles", c_we, D2);
    check_val("s1_pix_rd_cycles", c_rd, N);
    check_val("s1_valid_pulses", c_vld, VALID_PER_FRAME);
    check_val("s1_frame_done", c_done, 1);

    // Frame from READY; a start mid-STREAM and a reload mid-DRAIN are both ignored.
    clear_counts();
    tick(1, 0, 0);
    repeat (10) tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (45) tick(0, 0, 0);
    tick(0, 1, 0);
    wait_ready("s2");
    check_val("s2_frame_done", c_done, 1);
    check_val("s2_lut_we_cycles", c_we, 0);

    // start and lut_reload together in READY: full reload, then the frame.
    clear_counts();
    tick(1, 1, 0);
    wait_ready("s3");
    check_val("s3_lut_we_cycles", c_we, D2);
    check_val("s3_frame_done", c_done, 1);

    // Back-to-back frames: second start in the cycle right after frame_done.
    clear_counts();
    tick(1, 0, 0);
    i = 0;
    while (!(m_mode == M_FRAME && m_k == P + N) && i < 400) begin tick(0, 0, 0); i++; end
    tick(0, 0, 0);
    tick(1, 0, 0);
    wait_ready("s4");
    check_val("s4_frame_done", c_done, 2);
    check_val("s4_valid_pulses", c_vld, 2 * VALID_PER_FRAME);
    check_val("s4_lut_we_cycles", c_we, 0);

    // Reload alone, with a start arriving during LOAD.
    clear_counts();
    tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 0);
    wait_ready("s5");
    check_val("s5_lut_we_cycles", c_we, D2);
    check_val("s5_frame_done", c_done, 1);

    // Reset in LOAD cycle 4, then a fresh start reloads fully.
    clear_counts();
    tick(0, 1, 0);
    repeat (4) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    check_val("s6_abort_done", c_done, 0);
    clear_counts();
    tick(1, 0, 0);
    wait_ready("s6");
    check_val("s6_lut_we_cycles", c_we, D2);
    check_val("s6_frame_done", c_done, 1);

    // Reset mid-STREAM, then a fresh start reloads fully.
    clear_counts();
    tick(1, 0, 0);
    repeat (15) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    check_val("s7_abort_done", c_done, 0);
    clear_counts();
    tick(1, 0, 0);
    wait_ready("s7");
    check_val("s7_lut_we_cycles", c_we, D2);
    check_val("s7_frame_done", c_done, 1);

    // Random requests and occasional resets; start is withheld on the flush cycle.
    repeat (1500) begin
      s  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 299) == 0);
      if (m_mode == M_LOAD && m_k == D2) s = 1'b0;
      tick(s, r, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
